// File: rtl/gen_chk_multi.sv
// Multi-channel pattern generator / checker pairs.
// Each channel sources a seeded sequence and scores a returned stream.
module gen_chk_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int DELAY_GEN  = 2,
  parameter int DELAY_CHK  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         mode,
  output logic [NUM_CH-1:0]            gen_down_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] gen_down_data,
  input  logic [NUM_CH-1:0]            gen_down_ready,
  input  logic [NUM_CH-1:0]            chk_up_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] chk_up_data,
  output logic [NUM_CH-1:0]            chk_up_ready,
  output logic [NUM_CH-1:0]            err_flag,
  output logic [NUM_CH*CNT_WIDTH-1:0]  err_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0]  ok_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } gen_state_t;

  localparam int GW = (DELAY_GEN > 0) ? $clog2(DELAY_GEN + 1) : 1;
  localparam int CW = (DELAY_CHK > 0) ? $clog2(DELAY_CHK + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [DATA_WIDTH-1:0] next_word(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  m
  );
    if (m)
      next_word = {v[DATA_WIDTH-2:0],
                   v[DATA_WIDTH-1] ^ v[DATA_WIDTH-2]};
    else
      next_word = v + DATA_WIDTH'(1);
  endfunction

  // Keeps ready low until the first edge after reset release.
  logic live;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(c + 1);

    gen_state_t            state_q, state_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        gap_q   <= '0;
        word_q  <= SEED;
      end else begin
        state_q <= state_d;
        gap_q   <= gap_d;
        word_q  <= word_d;
      end
    end

    always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      word_d  = word_q;
      unique case (state_q)
        IDLE: if (enable) state_d = SEND;
        SEND: begin
          if (gen_down_ready[c]) begin
            word_d = next_word(word_q, mode);
            if (DELAY_GEN != 0) begin
              state_d = GAP;
              gap_d   = GW'(DELAY_GEN);
            end else begin
              state_d = enable ? SEND : IDLE;
            end
          end
        end
        GAP: begin
          gap_d = gap_q - 1'b1;
          if (gap_q == GW'(1)) state_d = enable ? SEND : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    assign gen_down_valid[c] = (state_q == SEND);
    assign gen_down_data[c*DATA_WIDTH +: DATA_WIDTH] = word_q;

    logic [CW-1:0]         hold_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [CNT_WIDTH-1:0]  ok_q, err_q;
    logic                  flag_q;
    logic                  rdy, chs, match;

    assign rdy   = live & enable & (hold_q == '0);
    assign chs   = rdy & chk_up_valid[c];
    assign match = chk_up_data[c*DATA_WIDTH +: DATA_WIDTH] == exp_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_q <= '0;
        exp_q  <= SEED;
        ok_q   <= '0;
        err_q  <= '0;
        flag_q <= 1'b0;
      end else if (chs) begin
        hold_q <= CW'(DELAY_CHK);
        exp_q  <= next_word(exp_q, mode);
        if (match) begin
          if (ok_q != CNT_MAX) ok_q <= ok_q + 1'b1;
        end else begin
          flag_q <= 1'b1;
          if (err_q != CNT_MAX) err_q <= err_q + 1'b1;
        end
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
    end

    assign chk_up_ready[c] = rdy;
    assign err_flag[c]     = flag_q;
    assign err_cnt[c*CNT_WIDTH +: CNT_WIDTH] = err_q;
    assign ok_cnt[c*CNT_WIDTH +: CNT_WIDTH]  = ok_q;
  end

endmodule

// File: doc/gen_chk_multi.md
GEN_CHK_MULTI -- requirements
Module: gen_chk_multi

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width per channel.
REQ-002 Parameter NUM_CH, default 2: number of independent generator/checker channel pairs (1..16).
REQ-003 Parameter DELAY_GEN, default 2: idle cycles the generator inserts after each accepted beat (0 = back-to-back).
REQ-004 Parameter DELAY_CHK, default 2: cycles the checker holds ready low after each accepted beat (0 = ready held high).
REQ-005 Parameter CNT_WIDTH, default 16: width of each per-channel statistics counter.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  global run enable for all generators and checkers.
REQ-009 mode  in  1  pattern select: 0 = increment, 1 = shift-feedback sequence.
REQ-010 gen_down_valid  out  NUM_CH  per-channel source valid.
REQ-011 gen_down_data  out  NUM_CH*DATA_WIDTH  source payload; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-012 gen_down_ready  in  NUM_CH  per-channel downstream ready.
REQ-013 chk_up_valid  in  NUM_CH  per-channel sink valid.
REQ-014 chk_up_data  in  NUM_CH*DATA_WIDTH  sink payload, same packing as gen_down_data.
REQ-015 chk_up_ready  out  NUM_CH  per-channel sink ready.
REQ-016 err_flag  out  NUM_CH  sticky per-channel mismatch flag.
REQ-017 err_cnt  out  NUM_CH*CNT_WIDTH  per-channel mismatch count, packed as data.
REQ-018 ok_cnt  out  NUM_CH*CNT_WIDTH  per-channel count of matching accepted beats, packed as data.

Function
REQ-019 Handshake on any port SHALL complete on a rising edge where valid and ready are both high.
REQ-020 Seed for channel c SHALL be c+1 (zero-extended); generator word and checker expected value both start at seed.
REQ-021 Next-value rule, evaluated with mode as sampled on the handshake cycle: mode 0 -> v+1 mod 2^DATA_WIDTH; mode 1 -> {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]^v[DATA_WIDTH-2]}.
REQ-022 Generator FSM per channel SHALL have states IDLE, SEND, GAP.
REQ-023 IDLE -> SEND when enable=1; valid=1 in SEND only.
REQ-024 In SEND, valid and data SHALL hold stable until handshake, regardless of enable or mode changes.
REQ-025 On SEND handshake: data advances per REQ-021; next state GAP with counter loaded DELAY_GEN, or SEND directly if DELAY_GEN=0 and enable=1, else IDLE.
REQ-026 GAP decrements one per cycle; on reaching 0 go to SEND if enable=1, else IDLE; first re-assertion of valid is exactly DELAY_GEN cycles after the handshake edge.
REQ-027 Checker ready SHALL be high when enable=1 and its gap counter is 0; after a handshake the counter loads DELAY_CHK, holding ready low DELAY_CHK cycles.
REQ-028 On checker handshake: data == expected -> ok_cnt+1; else err_cnt+1 and err_flag set; expected advances per REQ-021 from expected (not received data) in both cases.
REQ-029 ok_cnt and err_cnt SHALL saturate at all-ones, not wrap.
REQ-030 err_flag SHALL clear only on reset.
REQ-031 Channels SHALL be fully independent; a stall on one channel never affects another.

Reset
REQ-032 With rst low, asynchronously: all valid 0, all ready 0, generator FSMs IDLE, gap counters 0, gen_down_data and expected values = seed, err_flag 0, all counters 0.
REQ-033 Reset asserted mid-transfer SHALL abort the pending beat; after release, sequences restart from seed.
REQ-034 First valid/ready SHALL assert no earlier than the first rising edge after rst deasserts with enable=1.

Verification
REQ-035 NUM_CH=2, mode 0, gen_down looped to chk_up, enable=1, 20 beats/channel -> ch0 data 1..20, ch1 data 2..21, ok_cnt 20 each, err_cnt 0, err_flag 0.
REQ-036 DELAY_GEN=2, downstream ready held 1 -> valid pattern 1,0,0,1,0,0...; ready held low 5 cycles in SEND -> data unchanged throughout.
REQ-037 Mode 1, DATA_WIDTH=8, ch0 -> sequence 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x81; checker with same mode reports 0 errors.
REQ-038 Inject bit flip on ch1 beat 3 only -> ch1 err_cnt 1, err_flag 1, following beats counted in ok_cnt; ch0 unaffected.
REQ-039 CNT_WIDTH=4, 20 mismatches -> err_cnt holds 15.
REQ-040 Assert rst while ch0 valid=1 and ready=0 -> valid drops immediately, counters 0; after release first word is 1.
